// File: rtl/axis_ins_hdr_pkg.sv
// Shared types and defaults for the AXI-Stream header inserter.
// Used by axi_stream_insert_header and its payload FIFO.
package axis_ins_hdr_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_KEEP_WIDTH  = DEF_DATA_WIDTH / 8;
  localparam int unsigned DEF_FIFO_DEPTH  = 8;
  localparam int unsigned DEF_ENTRY_WIDTH = DEF_DATA_WIDTH + DEF_KEEP_WIDTH + 1;

  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_BODY = 1'b1
  } state_e;

  // One FIFO entry packs {data, keep, last}.
  function automatic int unsigned entry_width(input int unsigned data_w,
                                              input int unsigned keep_w);
    return data_w + keep_w + 1;
  endfunction

endpackage

// File: rtl/axis_ins_hdr_fifo.sv
// Synchronous payload FIFO with wrap-bit pointers and same-cycle push/pop.
// A push while full is only taken when a pop happens in the same cycle.
module axis_ins_hdr_fifo
  import axis_ins_hdr_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_ENTRY_WIDTH,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  // NOTE: sequential state always uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/axi_stream_insert_header.sv
// Prepends one header word to every AXI-Stream packet; payload is buffered in a FIFO.
// Define AXIS_INS_HDR_OVF_EN to add a sticky 'overflow' output for dropped payload beats.
module axi_stream_insert_header
  import axis_ins_hdr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_insert,
  input  logic                  valid_insert,
  output logic                  ready_insert,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  last_in,
  input  logic [KEEP_WIDTH-1:0] keep_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  last_out,
  output logic [KEEP_WIDTH-1:0] keep_out,
  output logic                  valid_out,
`ifdef AXIS_INS_HDR_OVF_EN
  output logic                  overflow,
`endif
  input  logic                  ready_out
);

  localparam int unsigned ENTRY_W = entry_width(DATA_WIDTH, KEEP_WIDTH);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [KEEP_WIDTH-1:0] keep_q;
  logic                  last_q;
  logic                  valid_q;

  logic                  load_ok;
  logic                  pop;
  logic                  push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    rd_entry;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [KEEP_WIDTH-1:0] rd_keep;
  logic                  rd_last;

  assign load_ok = !valid_q || ready_out;
  assign pop     = (state_q == ST_BODY) && load_ok && !fifo_empty;
  // A full FIFO still accepts a beat when the same cycle frees a slot.
  assign push    = valid_in && (!fifo_full || pop);

  assign wr_entry                   = {data_in, keep_in, last_in};
  assign {rd_data, rd_keep, rd_last} = rd_entry;

  assign ready_insert = (state_q == ST_HDR) && load_ok;

  axis_ins_hdr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (rd_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_HDR;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_HDR: begin
          if (load_ok) begin
            if (valid_insert) begin
              data_q  <= data_insert;
              keep_q  <= '1;
              last_q  <= 1'b0;
              valid_q <= 1'b1;
              state_q <= ST_BODY;
            end else begin
              valid_q <= 1'b0;
            end
          end
        end
        ST_BODY: begin
          if (load_ok) begin
            if (!fifo_empty) begin
              data_q  <= rd_data;
              keep_q  <= rd_keep;
              last_q  <= rd_last;
              valid_q <= 1'b1;
              if (rd_last) state_q <= ST_HDR;
            end else begin
              valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= ST_HDR;
      endcase
    end
  end

  assign data_out  = data_q;
  assign keep_out  = keep_q;
  assign last_out  = last_q;
  assign valid_out = valid_q;

`ifdef AXIS_INS_HDR_OVF_EN
  logic drop;
  logic overflow_q;

  assign drop = valid_in && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Directed bench for axi_stream_insert_header: a vector table for the basic flow,
// plus hand-written sequences for back-pressure, overflow and mid-packet reset.
module tb_axi_stream_insert_header;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_insert;
  logic        valid_insert;
  logic        ready_insert;
  logic [31:0] data_in;
  logic        last_in;
  logic [3:0]  keep_in;
  logic        valid_in;
  logic [31:0] data_out;
  logic        last_out;
  logic [3:0]  keep_out;
  logic        valid_out;
  logic        ready_out;
`ifdef AXIS_INS_HDR_OVF_EN
  logic        overflow;
`endif

  always #5 clk = ~clk;

  axi_stream_insert_header #(
    .DATA_WIDTH (32),
    .KEEP_WIDTH (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_insert  (data_insert),
    .valid_insert (valid_insert),
    .ready_insert (ready_insert),
    .data_in      (data_in),
    .last_in      (last_in),
    .keep_in      (keep_in),
    .valid_in     (valid_in),
    .data_out     (data_out),
    .last_out     (last_out),
    .keep_out     (keep_out),
    .valid_out    (valid_out),
`ifdef AXIS_INS_HDR_OVF_EN
    .overflow     (overflow),
`endif
    .ready_out    (ready_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic hv, input logic [31:0] h, input logic iv,
                       input logic [31:0] d, input logic [3:0] k, input logic l,
                       input logic r);
    valid_insert = hv;
    data_insert  = h;
    valid_in     = iv;
    data_in      = d;
    keep_in      = k;
    last_in      = l;
    ready_out    = r;
  endtask

  task automatic check_beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                            input logic l);
    check({tag, ".valid"}, {31'd0, valid_out}, 32'd1);
    check({tag, ".data"},  data_out, d);
    check({tag, ".keep"},  {28'd0, keep_out}, {28'd0, k});
    check({tag, ".last"},  {31'd0, last_out}, {31'd0, l});
  endtask

  typedef struct {
    logic        hv;
    logic [31:0] h;
    logic        iv;
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        r;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
    logic        eri;
  } vec_t;

  function automatic vec_t mk(input logic hv, input logic [31:0] h, input logic iv,
                              input logic [31:0] d, input logic [3:0] k, input logic l,
                              input logic ev, input logic [31:0] ed, input logic [3:0] ek,
                              input logic el, input logic eri);
    vec_t v;
    v.hv = hv; v.h = h; v.iv = iv; v.d = d; v.k = k; v.l = l; v.r = 1'b1;
    v.ev = ev; v.ed = ed; v.ek = ek; v.el = el; v.eri = eri;
    return v;
  endfunction

  vec_t        vecs[17];
  logic [31:0] beat_d[10];

  initial begin
    // Header + payload, header immediately followed by its beats.
    vecs[0]  = mk(1, 32'h12345678, 1, 32'habcdef01, 4'hF, 0, 1, 32'h12345678, 4'hF, 0, 0);
    vecs[1]  = mk(0, 32'h0,        1, 32'h00000002, 4'h3, 1, 1, 32'habcdef01, 4'hF, 0, 0);
    vecs[2]  = mk(0, 32'h0,        0, 32'h0,        4'h0, 0, 1, 32'h00000002, 4'h3, 1, 1);
    vecs[3]  = mk(0, 32'h0,        0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 0, 1);
    // Payload before header: nothing leaves until the header arrives.
    vecs[4]  = mk(0, 32'h0,        1, 32'h000000a1, 4'hF, 0, 0, 32'h0,        4'h0, 0, 1);
    vecs[5]  = mk(0, 32'h0,        1, 32'h000000a2, 4'hF, 0, 0, 32'h0,        4'h0, 0, 1);
    vecs[6]  = mk(0, 32'h0,        1, 32'h000000a3, 4'h1, 1, 0, 32'h0,        4'h0, 0, 1);
    vecs[7]  = mk(1, 32'hcafef00d, 0, 32'h0,        4'h0, 0, 1, 32'hcafef00d, 4'hF, 0, 0);
    vecs[8]  = mk(0, 32'h0,        0, 32'h0,        4'h0, 0, 1, 32'h000000a1, 4'hF, 0, 0);
    vecs[9]  = mk(0, 32'h0,        0, 32'h0,        4'h0, 0, 1, 32'h000000a2, 4'hF, 0, 0);
    vecs[10] = mk(0, 32'h0,        0, 32'h0,        4'h0, 0, 1, 32'h000000a3, 4'h1, 1, 1);
    vecs[11] = mk(0, 32'h0,        0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 0, 1);
    // Header with no payload yet: BODY waits with valid_out low.
    vecs[12] = mk(1, 32'h11112222, 0, 32'h0,        4'h0, 0, 1, 32'h11112222, 4'hF, 0, 0);
    vecs[13] = mk(0, 32'h0,        0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 0, 0);
    vecs[14] = mk(0, 32'h0,        1, 32'h000000b1, 4'hF, 1, 0, 32'h0,        4'h0, 0, 0);
    vecs[15] = mk(0, 32'h0,        0, 32'h0,        4'h0, 0, 1, 32'h000000b1, 4'hF, 1, 1);
    // Next header loads directly after the previous last beat leaves.
    vecs[16] = mk(1, 32'h33334444, 0, 32'h0,        4'h0, 0, 1, 32'h33334444, 4'hF, 0, 0);

    // Reset
    drive(0, 32'h0, 0, 32'h0, 4'h0, 0, 1);
    rst = 1'b0;
    step();
    step();
    check("rst.valid", {31'd0, valid_out}, 32'd0);
    check("rst.data",  data_out, 32'd0);
    check("rst.keep",  {28'd0, keep_out}, 32'd0);
    check("rst.last",  {31'd0, last_out}, 32'd0);
`ifdef AXIS_INS_HDR_OVF_EN
    check("rst.overflow", {31'd0, overflow}, 32'd0);
`endif
    rst = 1'b1;
    step();
    check("rst.ready_insert", {31'd0, ready_insert}, 32'd1);

    // Vector table
    for (int i = 0; i < 17; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].hv, vecs[i].h, vecs[i].iv, vecs[i].d, vecs[i].k, vecs[i].l, vecs[i].r);
      step();
      check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, vecs[i].ev});
      if (vecs[i].ev) begin
        check({tag, ".data"}, data_out, vecs[i].ed);
        check({tag, ".keep"}, {28'd0, keep_out}, {28'd0, vecs[i].ek});
        check({tag, ".last"}, {31'd0, last_out}, {31'd0, vecs[i].el});
      end
      check({tag, ".ready_insert"}, {31'd0, ready_insert}, {31'd0, vecs[i].eri});
    end

    // Back-pressure: header 33334444 is on the outputs; stall 4 cycles while pushing.
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h0, 1, 32'hc0 + i, 4'hF, (i == 3), 0);
      step();
      check_beat($sformatf("bp_hold%0d", i), 32'h33334444, 4'hF, 0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h0, 0, 32'h0, 4'h0, 0, 1);
      step();
      check_beat($sformatf("bp_out%0d", i), 32'hc0 + i, 4'hF, (i == 3));
    end
    step();
    check("bp_end.valid", {31'd0, valid_out}, 32'd0);

    // Overflow: 10 beats into an 8-deep FIFO with no header; last two are dropped.
    for (int i = 0; i < 10; i++) begin
      beat_d[i] = 32'hd0000000 + i;
      drive(0, 32'h0, 1, beat_d[i], 4'hF, (i == 7), 0);
      step();
    end
    check("ovf_idle.valid", {31'd0, valid_out}, 32'd0);
    drive(1, 32'heeee0000, 0, 32'h0, 4'h0, 0, 1);
    step();
    check_beat("ovf_hdr", 32'heeee0000, 4'hF, 0);
    drive(0, 32'h0, 0, 32'h0, 4'h0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      check_beat($sformatf("ovf_out%0d", i), beat_d[i], 4'hF, (i == 7));
    end
    step();
    check("ovf_end.valid", {31'd0, valid_out}, 32'd0);
`ifdef AXIS_INS_HDR_OVF_EN
    check("ovf.overflow", {31'd0, overflow}, 32'd1);
`endif

    // Reset mid-packet discards the partial packet and the buffered payload.
    drive(1, 32'hf00df00d, 0, 32'h0, 4'h0, 0, 1);
    step();
    drive(0, 32'h0, 1, 32'h00000055, 4'hF, 1, 0);
    step();
    drive(0, 32'h0, 0, 32'h0, 4'h0, 0, 0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst.valid", {31'd0, valid_out}, 32'd0);
    check("mid_rst.data",  data_out, 32'd0);
    step();
    rst = 1'b1;
    step();
    check("mid_rst.ready_insert", {31'd0, ready_insert}, 32'd1);
    drive(1, 32'h77770000, 0, 32'h0, 4'h0, 0, 1);
    step();
    check_beat("mid_rst_hdr", 32'h77770000, 4'hF, 0);
    drive(0, 32'h0, 0, 32'h0, 4'h0, 0, 1);
    step();
    check("mid_rst_empty.valid", {31'd0, valid_out}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
